texture_load_scheduler: RTL and testbench

Sequences 32-bit uploads into the 128-slot texture memory and shares its single read port between NUM_REQ texture-fetch requesters. Accepts load commands (slot, word count) and a valid/ready data stream, and generates the memory write port (wdata/wea/waddr). Tracks which slots hold complete textures. Round-robin arbitration gives one read grant per cycle and blocks reads of the slot currently being loaded.

---
 rtl/texture_load_scheduler.sv | 150 +++++++++++++++
 tb/tb_texture_load_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/texture_load_scheduler.sv
// Texture load scheduler: sequences slot uploads into the texture memory write port
// and round-robin arbitrates the shared read port among NUM_REQ requesters.
module texture_load_scheduler #(
    parameter int unsigned NUM_REQ  = 2,
    parameter logic [26:0] TEX_BASE = 27'h0002000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic [6:0]             i_cmd_slot,
    input  logic [5:0]             i_cmd_words,
    input  logic                   i_abort,
    input  logic                   i_data_valid,
    output logic                   o_data_ready,
    input  logic [31:0]            i_data,
    output logic [31:0]            o_wdata,
    output logic                   o_wea,
    output logic [26:0]            o_waddr,
    input  logic [NUM_REQ-1:0]     i_rd_req,
    input  logic [8*NUM_REQ-1:0]   i_rd_idx,
    output logic [NUM_REQ-1:0]     o_rd_grant,
    output logic [7:0]             o_texture_idx,
    output logic [NUM_REQ-1:0]     o_rd_data_valid,
    output logic [127:0]           o_slot_resident,
    output logic                   o_busy,
    output logic                   o_done
);
    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    state_t state, next_state;

    logic [6:0]         slot;
    logic [5:0]         count;
    logic [5:0]         word;
    logic               cmd_ready;
    logic               cmd_fire;
    logic               beat_fire;
    logic               last_beat;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      sel;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] valid_s1;

    assign cmd_fire  = i_cmd_valid && cmd_ready;
    assign beat_fire = (state == LOAD) && i_data_valid && !i_abort;
    assign last_beat = beat_fire && (word == count);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state   = state;
        o_data_ready = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        unique case (state)
            IDLE: if (cmd_fire) next_state = LOAD;
            LOAD: begin
                o_data_ready = 1'b1;
                o_busy       = 1'b1;
                if (i_abort)        next_state = IDLE;
                else if (last_beat) next_state = DONE;
            end
            DONE: begin
                o_done     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Registered so ready stays low in the first cycle after reset, then tracks IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) cmd_ready <= 1'b0;
        else        cmd_ready <= (next_state == IDLE);
    end
    assign o_cmd_ready = cmd_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot            <= '0;
            count           <= '0;
            word            <= '0;
            o_wea           <= 1'b0;
            o_wdata         <= '0;
            o_waddr         <= '0;
            o_slot_resident <= '0;
        end else begin
            o_wea <= beat_fire;
            if (cmd_fire) begin
                slot                        <= i_cmd_slot;
                count                       <= i_cmd_words;
                word                        <= '0;
                o_slot_resident[i_cmd_slot] <= 1'b0;
            end
            if (beat_fire) begin
                o_wdata <= i_data;
                o_waddr <= TEX_BASE + {12'd0, slot, word, 2'b00};
                word    <= word + 6'd1;
            end
            if (last_beat) o_slot_resident[slot] <= 1'b1;
        end
    end

    // Rotating priority search starting at rr_ptr; busy/slot compare uses registered state only.
    always_comb begin
        int unsigned cand;
        logic [PW-1:0] cidx;
        logic found;
        eligible = '0;
        grant    = '0;
        sel      = '0;
        found    = 1'b0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            eligible[r] = rst_n && i_rd_req[r] && !(o_busy && (i_rd_idx[8*r +: 7] == slot));
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(rr_ptr) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cidx = PW'(cand);
            if (!found && eligible[cidx]) begin
                found       = 1'b1;
                grant[cidx] = 1'b1;
                sel         = cidx;
            end
        end
    end
    assign o_rd_grant = grant;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr          <= '0;
            o_texture_idx   <= '0;
            valid_s1        <= '0;
            o_rd_data_valid <= '0;
        end else begin
            valid_s1        <= grant;
            o_rd_data_valid <= valid_s1;
            if (|grant) begin
                o_texture_idx <= i_rd_idx[8*sel +: 8];
                rr_ptr        <= (sel == PW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_texture_load_scheduler.sv
// Self-checking bench for texture_load_scheduler: directed scenarios plus random
// traffic, compared every cycle against a behavioural model of load/read rules.
module tb_texture_load_scheduler;
    localparam int N = 2;
    localparam logic [26:0] BASE = 27'h0002000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cmd_valid = 1'b0;
    logic [6:0]     cmd_slot = '0;
    logic [5:0]     cmd_words = '0;
    logic           abort = 1'b0;
    logic           data_valid = 1'b0;
    logic [31:0]    data = '0;
    logic [N-1:0]   rd_req = '0;
    logic [8*N-1:0] rd_idx = '0;

    logic           cmd_ready, data_ready, wea, busy, done;
    logic [31:0]    wdata;
    logic [26:0]    waddr;
    logic [N-1:0]   rd_grant, rd_data_valid;
    logic [7:0]     texture_idx;
    logic [127:0]   slot_resident;

    always #5 clk = ~clk;

    texture_load_scheduler #(.NUM_REQ(N), .TEX_BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_slot(cmd_slot), .i_cmd_words(cmd_words), .i_abort(abort),
        .i_data_valid(data_valid), .o_data_ready(data_ready), .i_data(data),
        .o_wdata(wdata), .o_wea(wea), .o_waddr(waddr),
        .i_rd_req(rd_req), .i_rd_idx(rd_idx), .o_rd_grant(rd_grant),
        .o_texture_idx(texture_idx), .o_rd_data_valid(rd_data_valid),
        .o_slot_resident(slot_resident), .o_busy(busy), .o_done(done)
    );

    // Behavioural model state: phase 0=idle 1=loading 2=done
    int           phase, m_slot, m_count, m_word, rr, g;
    bit           just_reset, m_wea, hs;
    logic [31:0]  m_wdata;
    logic [26:0]  m_waddr;
    logic [127:0] m_res;
    logic [7:0]   m_tidx;
    logic [N-1:0] v1, v2, e_grant;
    int           tests = 0, fails = 0, wcount = 0, donecount = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        phase = 0; just_reset = 1'b1; m_slot = 0; m_count = 0; m_word = 0; rr = 0;
        m_wea = 1'b0; m_wdata = '0; m_waddr = '0; m_res = '0; m_tidx = '0;
        v1 = '0; v2 = '0; hs = 1'b0;
    endtask

    task automatic cycle();
        bit rdy;
        e_grant = '0;
        g = -1;
        for (int i = 0; i < N; i++) begin
            int r;
            logic [7:0] ix;
            r  = (rr + i) % N;
            ix = rd_idx[8*r +: 8];
            if (g < 0 && rst_n && rd_req[r] && !(phase == 1 && int'(ix[6:0]) == m_slot)) g = r;
        end
        if (g >= 0) e_grant[g] = 1'b1;
        rdy = (phase == 0) && !just_reset;

        @(negedge clk);
        check("cmd_ready", cmd_ready, rdy);
        check("data_ready", data_ready, phase == 1);
        check("busy", busy, phase == 1);
        check("done", done, phase == 2);
        check("wea", wea, m_wea);
        check("wdata", wdata, m_wdata);
        check("waddr", waddr, m_waddr);
        check("rd_grant", rd_grant, e_grant);
        check("texture_idx", texture_idx, m_tidx);
        check("rd_data_valid", rd_data_valid, v2);
        check("slot_resident", slot_resident, m_res);
        if (wea === 1'b1) wcount++;
        if (done === 1'b1) donecount++;

        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            just_reset = 1'b0;
            v2 = v1;
            v1 = e_grant;
            if (g >= 0) begin
                m_tidx = rd_idx[8*g +: 8];
                rr = (g + 1) % N;
            end
            hs = (phase == 1) && data_valid && !abort;
            m_wea = hs;
            if (hs) begin
                m_wdata = data;
                m_waddr = BASE + 27'(m_slot * 256 + m_word * 4);
            end
            case (phase)
                0: if (cmd_valid && rdy) begin
                    m_slot = int'(cmd_slot); m_count = int'(cmd_words); m_word = 0;
                    m_res[cmd_slot] = 1'b0; phase = 1;
                end
                1: if (abort) phase = 0;
                   else if (hs) begin
                       if (m_word == m_count) begin phase = 2; m_res[m_slot] = 1'b1; end
                       else m_word++;
                   end
                default: phase = 0;
            endcase
        end
        #1;
    endtask

    task automatic start_cmd(input int s, input int w);
        for (int c = 0; c < 20 && !(phase == 0 && !just_reset); c++) cycle();
        cmd_valid = 1'b1; cmd_slot = 7'(s); cmd_words = 6'(w);
        cycle();
        cmd_valid = 1'b0;
    endtask

    // gap: idle beats before the first valid; abort_at/reset_at: beat index for event (-1 none)
    task automatic run_load(input int gap, input int abort_at, input int reset_at, input bit rnd);
        int beat = 0;
        int c = 0;
        while (phase == 1 && c < 400) begin
            data_valid = (c >= gap) && (!rnd || ($urandom % 4 != 0));
            data  = 32'h1000 + 32'(beat);
            abort = data_valid && (beat == abort_at);
            rst_n = !(data_valid && (beat == reset_at));
            cycle();
            if (hs) beat++;
            rst_n = 1'b1; abort = 1'b0;
            c++;
        end
        data_valid = 1'b0;
        check("load_ends", busy, 1'b0);
        cycle();
        cycle();
    endtask

    initial begin
        int w0, d0;
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (3) cycle();

        // Full 64-word back-to-back load into slot 5
        w0 = wcount; d0 = donecount;
        start_cmd(5, 63);
        run_load(0, -1, -1, 1'b0);
        check("full_writes", wcount - w0, 64);
        check("full_done", donecount - d0, 1);
        check("full_last_addr", waddr, 27'h00025FC);
        check("full_resident5", slot_resident[5], 1'b1);

        // Single word to slot 127 with a 3-cycle data gap
        w0 = wcount; d0 = donecount;
        start_cmd(127, 0);
        run_load(3, -1, -1, 1'b0);
        check("single_writes", wcount - w0, 1);
        check("single_addr", waddr, 27'h0009F00);
        check("single_done", donecount - d0, 1);

        // Abort together with beat 4
        w0 = wcount; d0 = donecount;
        start_cmd(9, 15);
        data_valid = 1'b1;
        for (int b = 0; b < 5; b++) begin
            data = 32'h2000 + 32'(b);
            abort = (b == 4);
            cycle();
        end
        abort = 1'b0; data_valid = 1'b0;
        check("abort_ready", cmd_ready, 1'b1);
        cycle(); cycle();
        check("abort_writes", wcount - w0, 4);
        check("abort_no_done", donecount - d0, 0);
        check("abort_resident9", slot_resident[9], 1'b0);

        // Round robin between two held requests
        rd_req = 2'b11; rd_idx = {8'd4, 8'd3};
        repeat (6) cycle();
        rd_req = '0;
        repeat (3) cycle();

        // Busy block: requester 0 wants the slot being loaded
        rd_req = 2'b11; rd_idx = {8'd8, 8'd7};
        start_cmd(7, 7);
        run_load(1, -1, -1, 1'b1);
        rd_req = '0;
        repeat (3) cycle();

        // Bit 7 set on an index that matches the loading slot still blocks
        rd_req = 2'b01; rd_idx = {8'd0, 8'h8B};
        start_cmd(11, 2);
        run_load(2, -1, -1, 1'b0);
        rd_req = '0;
        cycle();

        // Reset for one cycle during beat 10
        start_cmd(20, 31);
        run_load(0, -1, 10, 1'b0);
        check("reset_resident", slot_resident, 128'd0);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            cmd_valid = ($urandom % 3 == 0);
            cmd_slot  = 7'($urandom);
            cmd_words = 6'($urandom % 8);
            data_valid = ($urandom % 3 != 0);
            data  = $urandom;
            abort = ($urandom % 40 == 0);
            rst_n = ($urandom % 250 != 0);
            for (int r = 0; r < N; r++) begin
                if (!rd_req[r] || e_grant[r]) begin
                    rd_req[r] = 1'($urandom % 2);
                    rd_idx[8*r +: 8] = ($urandom % 3 == 0) ? {1'($urandom), 7'(m_slot)} : 8'($urandom);
                end
            end
            cycle();
        end
        cmd_valid = 1'b0; data_valid = 1'b0; abort = 1'b0; rst_n = 1'b1; rd_req = '0;
        repeat (3) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
